// File: rtl/pixel_row_receiver.sv
`default_nettype none
// ============================================================================
// Module   : pixel_row_receiver
// Purpose  : Receive side of the pixel output bus. Collects BUS_PIXELS-wide
//            beats, reassembles them into a ROW_PIXELS-wide sensor row and
//            hands each row downstream through a valid/ready holding
//            register, tracking the row index within a frame.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            bus_valid, bus_data  - incoming beat qualifier and payload
//            row_ready            - consumer accepts the held row
//            clear_err            - clears the sticky error flags
//            row_valid, row_data  - held row and its qualifier
//            row_index            - frame row number of the held row
//            frame_done           - one-cycle pulse when the last row of a
//                                   frame completes (delivered or dropped)
//            overrun_err          - sticky: a completed row was dropped
//            short_row_err        - sticky: bus_valid fell mid-row
//            row_sum              - (PIXEL_ROW_CHECKSUM_EN only) sum of the
//                                   held row's pixels
// Options  : `define PIXEL_ROW_CHECKSUM_EN adds the row_sum output and its
//            beat-by-beat accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_row_receiver #(
    parameter int ROW_PIXELS = 8,
    parameter int BUS_PIXELS = 2,
    parameter int PIXEL_BITS = 8,
    parameter int ROWS       = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                bus_valid,
    input  logic [BUS_PIXELS*PIXEL_BITS-1:0]    bus_data,
    input  logic                                row_ready,
    input  logic                                clear_err,
    output logic                                row_valid,
    output logic [ROW_PIXELS*PIXEL_BITS-1:0]    row_data,
    output logic [$clog2(ROWS)-1:0]             row_index,
    output logic                                frame_done,
    output logic                                overrun_err,
    output logic                                short_row_err
`ifdef PIXEL_ROW_CHECKSUM_EN
    ,
    output logic [PIXEL_BITS+$clog2(ROW_PIXELS)-1:0] row_sum
`endif
);

    localparam int c_BEATS     = ROW_PIXELS / BUS_PIXELS;
    localparam int c_BEAT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_BEAT_BITS = BUS_PIXELS * PIXEL_BITS;
    localparam int c_ROW_BITS  = ROW_PIXELS * PIXEL_BITS;
    localparam int c_IDX_W     = $clog2(ROWS);

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_ROW  = c_IDX_W'(ROWS - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RECV = 1'b1;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (ROW_PIXELS % BUS_PIXELS != 0) begin : g_bad_bus_width
            $error("pixel_row_receiver: ROW_PIXELS must be a multiple of BUS_PIXELS");
        end
        if (ROWS < 2) begin : g_bad_rows
            $error("pixel_row_receiver: ROWS must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [c_BEAT_W-1:0]   w_beat_cnt_next;
    logic [c_BEAT_W-1:0]   w_beat_idx;
    logic [c_IDX_W-1:0]    r_row_cnt;
    logic [c_IDX_W-1:0]    w_row_cnt_next;
    logic [c_ROW_BITS-1:0] r_asm;
    logic [c_ROW_BITS-1:0] w_asm_row;

    logic                  w_capture;
    logic                  w_row_complete;
    logic                  w_short_row;
    logic                  w_load;
    logic                  w_overrun;

    logic                  r_row_valid;
    logic [c_ROW_BITS-1:0] r_row_data;
    logic [c_IDX_W-1:0]    r_row_index;
    logic                  r_frame_done;
    logic                  r_overrun_err;
    logic                  r_short_row_err;

    // ------------------------------------------------------------------------
    // Beat-collection FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Beat-collection FSM: next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        w_capture       = 1'b0;
        w_row_complete  = 1'b0;
        w_short_row     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus_valid) begin
                    w_capture = 1'b1;
                    if (c_BEATS == 1) begin
                        // Single-beat rows finish on their only beat.
                        w_row_complete  = 1'b1;
                        w_beat_cnt_next = '0;
                    end else begin
                        w_beat_cnt_next = c_BEAT_W'(1);
                        w_state_next    = c_ST_RECV;
                    end
                end
            end
            c_ST_RECV: begin
                if (bus_valid) begin
                    w_capture = 1'b1;
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_row_complete  = 1'b1;
                        w_beat_cnt_next = '0;
                        w_state_next    = c_ST_IDLE;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + c_BEAT_W'(1);
                    end
                end else begin
                    // The transmitter never pauses inside a row, so a gap
                    // means the row is broken; drop it and resynchronise.
                    w_short_row     = 1'b1;
                    w_beat_cnt_next = '0;
                    w_state_next    = c_ST_IDLE;
                end
            end
            default: begin
                w_beat_cnt_next = '0;
                w_state_next    = c_ST_IDLE;
            end
        endcase
    end

    // Beat slot being written this cycle; IDLE always starts a new row.
    assign w_beat_idx = (r_state == c_ST_IDLE) ? '0 : r_beat_cnt;

    // ------------------------------------------------------------------------
    // Row assembly: the assembly register merged with the current beat, so a
    // completed row can go straight into the holding register.
    // ------------------------------------------------------------------------
    always_comb begin
        w_asm_row = r_asm;
        for (int b = 0; b < c_BEATS; b++) begin
            if (w_beat_idx == c_BEAT_W'(b)) begin
                w_asm_row[b*c_BEAT_BITS +: c_BEAT_BITS] = bus_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm <= '0;
        end else if (w_capture) begin
            r_asm <= w_asm_row;
        end
    end

    // ------------------------------------------------------------------------
    // Holding register and frame row counter
    // ------------------------------------------------------------------------
    // The holding register accepts a new row if empty or emptied at this edge.
    assign w_load    = w_row_complete && (!r_row_valid || row_ready);
    assign w_overrun = w_row_complete && r_row_valid && !row_ready;

    assign w_row_cnt_next = (r_row_cnt == c_LAST_ROW) ? '0 : r_row_cnt + c_IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_valid  <= 1'b0;
            r_row_data   <= '0;
            r_row_index  <= '0;
            r_row_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_load) begin
                r_row_valid <= 1'b1;
                r_row_data  <= w_asm_row;
                r_row_index <= r_row_cnt;
            end else if (r_row_valid && row_ready) begin
                r_row_valid <= 1'b0;
            end
            // Dropped rows still consume a row number so the frame stays
            // aligned with the sensor.
            if (w_row_complete) begin
                r_row_cnt <= w_row_cnt_next;
            end
            r_frame_done <= w_row_complete && (r_row_cnt == c_LAST_ROW);
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags; a new event wins over a simultaneous clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun_err   <= 1'b0;
            r_short_row_err <= 1'b0;
        end else begin
            if (w_overrun) begin
                r_overrun_err <= 1'b1;
            end else if (clear_err) begin
                r_overrun_err <= 1'b0;
            end
            if (w_short_row) begin
                r_short_row_err <= 1'b1;
            end else if (clear_err) begin
                r_short_row_err <= 1'b0;
            end
        end
    end

    assign row_valid     = r_row_valid;
    assign row_data      = r_row_data;
    assign row_index     = r_row_index;
    assign frame_done    = r_frame_done;
    assign overrun_err   = r_overrun_err;
    assign short_row_err = r_short_row_err;

`ifdef PIXEL_ROW_CHECKSUM_EN
    // ------------------------------------------------------------------------
    // Row checksum, accumulated one beat at a time alongside assembly.
    // ------------------------------------------------------------------------
    localparam int c_SUM_W = PIXEL_BITS + $clog2(ROW_PIXELS);

    logic [c_SUM_W-1:0] r_asm_sum;
    logic [c_SUM_W-1:0] w_beat_sum;
    logic [c_SUM_W-1:0] w_row_sum_next;
    logic [c_SUM_W-1:0] r_row_sum;

    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < BUS_PIXELS; k++) begin
            w_beat_sum = w_beat_sum + c_SUM_W'(bus_data[k*PIXEL_BITS +: PIXEL_BITS]);
        end
    end

    // Beat 0 restarts the sum, discarding any residue of a broken row.
    assign w_row_sum_next = ((w_beat_idx == '0) ? '0 : r_asm_sum) + w_beat_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm_sum <= '0;
            r_row_sum <= '0;
        end else begin
            if (w_capture) begin
                r_asm_sum <= w_row_sum_next;
            end
            if (w_load) begin
                r_row_sum <= w_row_sum_next;
            end
        end
    end

    assign row_sum = r_row_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_row_receiver
// Purpose  : Directed self-checking bench for pixel_row_receiver with the
//            default parameters (8 pixels/row, 2 pixels/beat, 8-bit pixels,
//            4 rows/frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_row_receiver;

    logic        clk;
    logic        reset;
    logic        bus_valid;
    logic [15:0] bus_data;
    logic        row_ready;
    logic        clear_err;
    logic        row_valid;
    logic [63:0] row_data;
    logic [1:0]  row_index;
    logic        frame_done;
    logic        overrun_err;
    logic        short_row_err;
`ifdef PIXEL_ROW_CHECKSUM_EN
    logic [10:0] row_sum;
`endif

    int checks = 0;
    int errors = 0;

    pixel_row_receiver #(
        .ROW_PIXELS (8),
        .BUS_PIXELS (2),
        .PIXEL_BITS (8),
        .ROWS       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_valid     (bus_valid),
        .bus_data      (bus_data),
        .row_ready     (row_ready),
        .clear_err     (clear_err),
        .row_valid     (row_valid),
        .row_data      (row_data),
        .row_index     (row_index),
        .frame_done    (frame_done),
        .overrun_err   (overrun_err),
        .short_row_err (short_row_err)
`ifdef PIXEL_ROW_CHECKSUM_EN
        ,
        .row_sum       (row_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row whose pixel p holds base+p.
    function automatic logic [63:0] make_row(input logic [7:0] base);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 8; p++) r[p*8 +: 8] = base + 8'(p);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus_valid = 1'b0;
        bus_data  = '0;
        row_ready = 1'b0;
        clear_err = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // One beat with pixels base+2j and base+2j+1.
    task automatic send_beat(input logic [7:0] base, input int j);
        logic [7:0] p0;
        p0        = base + 8'(2 * j);
        bus_valid = 1'b1;
        bus_data  = {p0 + 8'd1, p0};
        tick();
    endtask

    // Four contiguous beats; optionally raise row_ready for the last beat.
    task automatic send_row(input logic [7:0] base, input logic ready_last);
        for (int j = 0; j < 4; j++) begin
            if (j == 3 && ready_last) row_ready = 1'b1;
            send_beat(base, j);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid: got %b expected 0", row_valid); end
        checks++; if (row_data !== 64'h0) begin errors++; $display("FAIL reset_row_data: got %h expected 0", row_data); end
        checks++; if ({row_index, frame_done, overrun_err, short_row_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {row_index, frame_done, overrun_err, short_row_err}); end
    endtask

    task automatic test_single_row();
        do_reset();
        row_ready = 1'b1;
        send_row(8'h00, 1'b0);
        bus_valid = 1'b0;
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", row_valid); end
        checks++; if (row_data !== 64'h0706050403020100) begin errors++; $display("FAIL single_data: got %h expected 0706050403020100", row_data); end
        checks++; if (row_index !== 2'd0) begin errors++; $display("FAIL single_index: got %0d expected 0", row_index); end
`ifdef PIXEL_ROW_CHECKSUM_EN
        checks++; if (row_sum !== 11'd28) begin errors++; $display("FAIL single_sum: got %0d expected 28", row_sum); end
`endif
        tick();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b expected 0", row_valid); end
    endtask

    task automatic test_full_frame();
        do_reset();
        row_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            send_row(8'(r * 16), 1'b0);
            checks++; if (row_valid !== 1'b1 || row_index !== 2'(r)) begin
                errors++; $display("FAIL frame_row%0d: got valid=%b index=%0d expected valid=1 index=%0d", r, row_valid, row_index, r); end
            checks++; if (row_data !== make_row(8'(r * 16))) begin
                errors++; $display("FAIL frame_data%0d: got %h expected %h", r, row_data, make_row(8'(r * 16))); end
            checks++; if (frame_done !== (r == 3)) begin
                errors++; $display("FAIL frame_done%0d: got %b expected %b", r, frame_done, (r == 3)); end
        end
        bus_valid = 1'b0;
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse: got %b expected 0", frame_done); end
        send_row(8'h50, 1'b0);
        bus_valid = 1'b0;
        checks++; if (row_index !== 2'd0 || row_data !== make_row(8'h50)) begin
            errors++; $display("FAIL frame_wrap: got index=%0d data=%h expected index=0 data=%h", row_index, row_data, make_row(8'h50)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        row_ready = 1'b0;
        send_row(8'h10, 1'b0);
        checks++; if (row_valid !== 1'b1 || row_index !== 2'd0) begin
            errors++; $display("FAIL bp_rowA: got valid=%b index=%0d expected valid=1 index=0", row_valid, row_index); end
        send_row(8'h20, 1'b0);
        bus_valid = 1'b0;
        checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun_err); end
        checks++; if (row_valid !== 1'b1 || row_index !== 2'd0 || row_data !== make_row(8'h10)) begin
            errors++; $display("FAIL bp_held: got valid=%b index=%0d data=%h expected 1 0 %h", row_valid, row_index, row_data, make_row(8'h10)); end
        row_ready = 1'b1;
        tick();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL bp_delivered: got %b expected 0", row_valid); end
        send_row(8'h30, 1'b0);
        bus_valid = 1'b0;
        checks++; if (row_index !== 2'd2 || row_data !== make_row(8'h30)) begin
            errors++; $display("FAIL bp_rowC: got index=%0d data=%h expected index=2 data=%h", row_index, row_data, make_row(8'h30)); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", overrun_err); end
    endtask

    task automatic test_simultaneous_free();
        do_reset();
        row_ready = 1'b0;
        send_row(8'h10, 1'b0);
        send_row(8'h20, 1'b1);
        bus_valid = 1'b0;
        checks++; if (row_valid !== 1'b1 || row_index !== 2'd1 || row_data !== make_row(8'h20)) begin
            errors++; $display("FAIL simul_load: got valid=%b index=%0d data=%h expected 1 1 %h", row_valid, row_index, row_data, make_row(8'h20)); end
        checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL simul_no_overrun: got %b expected 0", overrun_err); end
        tick();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b expected 0", row_valid); end
    endtask

    task automatic test_short_row();
        do_reset();
        row_ready = 1'b1;
        send_beat(8'h60, 0);
        send_beat(8'h60, 1);
        bus_valid = 1'b0;
        tick();
        checks++; if (short_row_err !== 1'b1 || row_valid !== 1'b0) begin
            errors++; $display("FAIL short_flag: got err=%b valid=%b expected err=1 valid=0", short_row_err, row_valid); end
        send_row(8'h40, 1'b0);
        bus_valid = 1'b0;
        checks++; if (row_valid !== 1'b1 || row_index !== 2'd0 || row_data !== make_row(8'h40)) begin
            errors++; $display("FAIL short_next_row: got valid=%b index=%0d data=%h expected 1 0 %h", row_valid, row_index, row_data, make_row(8'h40)); end
        // A clear coinciding with a fresh short row must leave the flag set.
        send_beat(8'h70, 0);
        bus_valid = 1'b0;
        clear_err = 1'b1;
        tick();
        checks++; if (short_row_err !== 1'b1) begin errors++; $display("FAIL short_clear_race: got %b expected 1", short_row_err); end
        tick();
        clear_err = 1'b0;
        checks++; if (short_row_err !== 1'b0) begin errors++; $display("FAIL short_clear: got %b expected 0", short_row_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        row_ready = 1'b0;
        send_row(8'h10, 1'b0);
        send_beat(8'h20, 0);
        send_beat(8'h20, 1);
        bus_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (row_valid !== 1'b0 || row_data !== 64'h0 || row_index !== 2'd0) begin
            errors++; $display("FAIL async_clear: got valid=%b index=%0d data=%h expected all 0", row_valid, row_index, row_data); end
        #1 reset = 1'b0;
        tick();
        row_ready = 1'b1;
        send_row(8'h00, 1'b0);
        bus_valid = 1'b0;
        checks++; if (row_valid !== 1'b1 || row_index !== 2'd0 || row_data !== 64'h0706050403020100) begin
            errors++; $display("FAIL async_next_row: got valid=%b index=%0d data=%h expected 1 0 0706050403020100", row_valid, row_index, row_data); end
        checks++; if (short_row_err !== 1'b0) begin errors++; $display("FAIL async_no_short: got %b expected 0", short_row_err); end
`ifdef PIXEL_ROW_CHECKSUM_EN
        checks++; if (row_sum !== 11'd28) begin errors++; $display("FAIL async_sum: got %0d expected 28", row_sum); end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        bus_valid = 1'b0;
        bus_data  = '0;
        row_ready = 1'b0;
        clear_err = 1'b0;
        test_reset();
        test_single_row();
        test_full_frame();
        test_backpressure();
        test_simultaneous_free();
        test_short_row();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
